// File: rtl/hub75_pkg.sv
// Shared HUB75 constants and types for the driver and the receiver.
package hub75_pkg;

  localparam int COLS      = 64;
  localparam int ADDR_BITS = 5;
  localparam int COL_BITS  = $clog2(COLS);

  localparam logic [15:0] FM_R1 = 16'h7FFF;
  localparam logic [15:0] FM_R2 = 16'h0040;

  typedef struct packed {
    logic [ADDR_BITS-1:0] row;
    logic [COL_BITS-1:0]  col;
    logic [5:0]           rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_EMIT  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/hub75_line_buf.sv
// Ping-pong line store: 2 banks x COLS words, bank select is the address MSB.
// Synchronous write, registered read with one cycle of latency.
module hub75_line_buf #(
  parameter int COLS = 64,
  parameter int W    = 6
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    i_wr_en,
  input  logic [$clog2(COLS):0]   i_wr_addr,
  input  logic [W-1:0]            i_wr_data,
  input  logic                    i_rd_en,
  input  logic [$clog2(COLS):0]   i_rd_addr,
  output logic [W-1:0]            o_rd_data
);

  logic [W-1:0] r_mem [2*COLS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn)    o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: oversamples the bus, rebuilds latched rows into a
// valid/ready pixel stream. Optional FM6126 register snooping: FM6126_SNOOP_EN.
//   state   | meaning
//   R_IDLE  | waiting for the read bank to be full
//   R_FETCH | buffer read issued at rcol
//   R_EMIT  | pixel presented, held until px_ready
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS        = hub75_pkg::COLS,
  parameter int ADDR_BITS   = hub75_pkg::ADDR_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      hub_sclk,
  input  logic                      hub_latch,
  input  logic                      hub_blank,
  input  logic [ADDR_BITS-1:0]      hub_addr,
  input  logic [2:0]                hub_rgb0,
  input  logic [2:0]                hub_rgb1,
  output logic                      px_valid,
  input  logic                      px_ready,
  output logic [ADDR_BITS-1:0]      px_row,
  output logic [$clog2(COLS)-1:0]   px_col,
  output logic [5:0]                px_rgb,
  output logic                      px_last,
  output logic                      row_err,
  output logic                      ovf,
  output logic                      blanked
`ifdef FM6126_SNOOP_EN
  ,
  output logic                      reg_valid,
  output logic [6:0]                reg_len,
  output logic [15:0]               reg_data
`endif
);

  localparam int CW      = $clog2(COLS);
  localparam int SW      = 3 + ADDR_BITS + 6;
  localparam int B_SCLK  = SW - 1;
  localparam int B_LATCH = SW - 2;
  localparam int B_BLANK = SW - 3;
  localparam logic [SW-1:0] SYNC_RST = {3'b001, {(ADDR_BITS + 6){1'b0}}};

  // All bus signals ride one vector so every bit sees the same latency.
  logic [SW-1:0] r_sync [SYNC_STAGES];
  logic [SW-1:0] w_s;
  logic          r_sclk_d, r_latch_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
      r_sclk_d  <= 1'b0;
      r_latch_d <= 1'b0;
    end else begin
      r_sync[0] <= {hub_sclk, hub_latch, hub_blank, hub_addr, hub_rgb1, hub_rgb0};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sclk_d  <= w_s[B_SCLK];
      r_latch_d <= w_s[B_LATCH];
    end
  end

  logic                 w_latch, w_sclk_rise, w_latch_fall;
  logic [ADDR_BITS-1:0] w_addr;
  logic [5:0]           w_rgb;

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_latch      = w_s[B_LATCH];
  assign w_addr       = w_s[ADDR_BITS+5:6];
  assign w_rgb        = w_s[5:0];
  assign w_sclk_rise  = w_s[B_SCLK] & ~r_sclk_d;
  assign w_latch_fall = ~w_latch & r_latch_d;
  assign blanked      = w_s[B_BLANK];

  logic                 r_wbank, r_rbank;
  logic [CW:0]          r_wcol;
  logic [CW-1:0]        r_rcol;
  logic [6:0]           r_lcnt;
  logic                 r_too_many, r_blocked;
  logic [1:0]           r_full;
  logic [ADDR_BITS-1:0] r_tag [2];
  logic                 r_row_err, r_ovf;

  logic w_wcol_full, w_bank_free, w_we, w_commit, w_err, w_ovf;
  logic w_rd_en, w_valid, w_xfer, w_rd_done;
  logic [5:0] w_rd_data;

  assign w_wcol_full = (r_wcol == (CW+1)'(COLS));
  assign w_bank_free = ~r_full[r_wbank] | (w_rd_done & (r_rbank == r_wbank));
  assign w_we        = w_sclk_rise & ~w_latch & ~w_latch_fall & ~w_wcol_full
                     & ~r_full[r_wbank];
  assign w_err       = w_latch_fall & (r_lcnt == 7'd0) & (~w_wcol_full | r_too_many);
  // A row whose shifts hit a still-full bank is incomplete, so it counts as overflow.
  assign w_ovf       = w_latch_fall & (r_lcnt == 7'd0) & w_wcol_full & ~r_too_many
                     & (~w_bank_free | r_blocked);
  assign w_commit    = w_latch_fall & (r_lcnt == 7'd0) & w_wcol_full & ~r_too_many
                     & ~r_blocked & w_bank_free;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wbank    <= 1'b0;
      r_wcol     <= '0;
      r_lcnt     <= '0;
      r_too_many <= 1'b0;
      r_blocked  <= 1'b0;
      r_tag[0]   <= '0;
      r_tag[1]   <= '0;
      r_row_err  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_latch_fall) begin
        r_wcol     <= '0;
        r_lcnt     <= '0;
        r_too_many <= 1'b0;
        r_blocked  <= 1'b0;
      end else if (w_sclk_rise) begin
        if (w_latch) begin
          if (r_lcnt != 7'h7F) r_lcnt <= r_lcnt + 7'd1;
        end else if (w_wcol_full) begin
          r_too_many <= 1'b1;
        end else begin
          r_wcol <= r_wcol + (CW+1)'(1);
          if (r_full[r_wbank]) r_blocked <= 1'b1;
        end
      end
      if (w_commit) begin
        r_tag[r_wbank] <= w_addr;
        r_wbank        <= ~r_wbank;
      end
      if (w_err) r_row_err <= 1'b1;
      if (w_ovf) r_ovf     <= 1'b1;
    end
  end

  // Commit after free so a bank released and refilled in one cycle ends up full.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_full <= 2'b00;
    end else begin
      if (w_rd_done) r_full[r_rbank] <= 1'b0;
      if (w_commit)  r_full[r_wbank] <= 1'b1;
    end
  end

  hub75_line_buf #(.COLS(COLS), .W(6)) u_buf (
    .i_clk     (clk),
    .i_resetn  (resetn),
    .i_wr_en   (w_we),
    .i_wr_addr ({r_wbank, r_wcol[CW-1:0]}),
    .i_wr_data (w_rgb),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rbank, r_rcol}),
    .o_rd_data (w_rd_data)
  );

  rd_state_e r_state, w_next;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_valid   = 1'b0;
    w_xfer    = 1'b0;
    w_rd_done = 1'b0;
    case (r_state)
      R_IDLE:  if (r_full[r_rbank]) w_next = R_FETCH;
      R_FETCH: begin
        w_rd_en = 1'b1;
        w_next  = R_EMIT;
      end
      R_EMIT: begin
        w_valid = 1'b1;
        if (px_ready) begin
          w_xfer = 1'b1;
          if (r_rcol == CW'(COLS - 1)) begin
            w_rd_done = 1'b1;
            w_next    = R_IDLE;
          end else begin
            w_next = R_FETCH;
          end
        end
      end
      default: w_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rbank <= 1'b0;
      r_rcol  <= '0;
    end else if (w_rd_done) begin
      r_rbank <= ~r_rbank;
      r_rcol  <= '0;
    end else if (w_xfer) begin
      r_rcol <= r_rcol + CW'(1);
    end
  end

  pixel_t w_px;

  assign w_px.row = r_tag[r_rbank];
  assign w_px.col = r_rcol;
  assign w_px.rgb = w_rd_data;

  assign px_valid = w_valid;
  assign px_row   = w_px.row;
  assign px_col   = w_px.col;
  assign px_rgb   = w_px.rgb;
  assign px_last  = w_valid & (r_rcol == CW'(COLS - 1));
  assign row_err  = r_row_err;
  assign ovf      = r_ovf;

`ifdef FM6126_SNOOP_EN
  logic [15:0] r_snoop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_snoop   <= '0;
      reg_valid <= 1'b0;
      reg_len   <= '0;
      reg_data  <= '0;
    end else begin
      reg_valid <= 1'b0;
      if (w_sclk_rise) r_snoop <= {r_snoop[14:0], w_rgb[0]};
      if (w_latch_fall && (r_lcnt != 7'd0)) begin
        reg_valid <= 1'b1;
        reg_len   <= r_lcnt;
        reg_data  <= r_snoop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: table-driven rows, stall/overflow/reset sequences and
// randomized rows against a row-level pixel model.
module tb_hub75_rx;

  localparam int NC = 64;

  logic       clk, resetn;
  logic       hub_sclk, hub_latch, hub_blank;
  logic [4:0] hub_addr;
  logic [2:0] hub_rgb0, hub_rgb1;
  logic       px_valid, px_ready;
  logic [4:0] px_row;
  logic [5:0] px_col;
  logic [5:0] px_rgb;
  logic       px_last, row_err, ovf, blanked;

  hub75_rx dut (
    .clk(clk), .resetn(resetn),
    .hub_sclk(hub_sclk), .hub_latch(hub_latch), .hub_blank(hub_blank),
    .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
    .px_valid(px_valid), .px_ready(px_ready), .px_row(px_row),
    .px_col(px_col), .px_rgb(px_rgb), .px_last(px_last),
    .row_err(row_err), .ovf(ovf), .blanked(blanked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [17:0] rx_q [$];
  logic [17:0] exp_q [$];
  logic [5:0]  tx_rgb [NC+8];
  logic        model_err;
  int          ready_mode;   // 0 low, 1 high, 2 random

  typedef struct {
    logic [4:0] addr;
    int         nshift;
    int         nlatch;
    int         exp_pix;
    logic       exp_err;
  } vec_t;
  vec_t tbl [6];

  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) px_ready = 1'($urandom_range(0, 1));
      else                 px_ready = (ready_mode == 1);
    end
  end

  always @(negedge clk)
    if (resetn && px_valid && px_ready) rx_q.push_back({px_row, px_col, px_rgb, px_last});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [4:0] addr, input int nshift, input int nlatch);
    hub_addr = addr;
    for (int i = 0; i < nshift; i++) begin
      hub_rgb0  = tx_rgb[i][2:0];
      hub_rgb1  = tx_rgb[i][5:3];
      hub_latch = (i >= nshift - nlatch);
      tick(4);
      hub_sclk = 1'b1;
      tick(4);
      hub_sclk = 1'b0;
    end
    if (nlatch == 0) begin
      tick(2);
      hub_latch = 1'b1;
      tick(4);
    end
    hub_latch = 1'b0;
    tick(6);
  endtask

  task automatic expect_row(input logic [4:0] addr);
    for (int i = 0; i < NC; i++)
      exp_q.push_back({addr, 6'(i), tx_rgb[i], (i == NC - 1)});
  endtask

  // A row becomes pixels only if it has exactly NC data shifts and no latched shifts.
  task automatic model_row(input logic [4:0] addr, input int nshift, input int nlatch);
    if (nlatch == 0) begin
      if (nshift == NC) expect_row(addr);
      else              model_err = 1'b1;
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NC + 8; i++) tx_rgb[i] = {~3'(i), 3'(i)};
  endtask

  task automatic fill_random();
    for (int i = 0; i < NC + 8; i++) tx_rgb[i] = 6'($urandom);
  endtask

  task automatic drain_cmp(input string tag);
    int guard;
    guard = 0;
    while (rx_q.size() < exp_q.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    repeat (40) @(negedge clk);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_pixel"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int n);
    int guard;
    guard = 0;
    while (rx_q.size() < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_rx_timeout", (guard < 2000), 1);
  endtask

  initial begin
    logic [18:0] snap;
    logic        stable;
    int          g, sel, ns, nl;
    logic [4:0]  a;

    tbl[0] = '{5'd5,  64, 0,  64, 1'b0};
    tbl[1] = '{5'd9,  64, 11, 0,  1'b0};
    tbl[2] = '{5'd31, 64, 0,  64, 1'b0};
    tbl[3] = '{5'd3,  63, 0,  0,  1'b1};
    tbl[4] = '{5'd7,  64, 0,  64, 1'b1};
    tbl[5] = '{5'd0,  65, 0,  0,  1'b1};

    resetn = 1'b0; hub_sclk = 1'b0; hub_latch = 1'b0; hub_blank = 1'b1;
    hub_addr = '0; hub_rgb0 = '0; hub_rgb1 = '0;
    ready_mode = 1; model_err = 1'b0;
    tick(4);
    chk("rst_valid",   px_valid, 0);
    chk("rst_outs",    {px_row, px_col, px_rgb, px_last}, 0);
    chk("rst_row_err", row_err, 0);
    chk("rst_ovf",     ovf, 0);
    chk("rst_blanked", blanked, 1);
    resetn = 1'b1;
    hub_blank = 1'b0;
    tick(6);
    chk("blanked_low", blanked, 0);

    for (int v = 0; v < 6; v++) begin
      fill_pattern();
      if (tbl[v].exp_pix == NC) expect_row(tbl[v].addr);
      send_row(tbl[v].addr, tbl[v].nshift, tbl[v].nlatch);
      drain_cmp("tbl");
      chk("tbl_row_err", row_err, tbl[v].exp_err);
    end

    // backpressure in the middle of a row
    fill_random();
    expect_row(5'd12);
    send_row(5'd12, NC, 0);
    wait_rx(20);
    ready_mode = 0;
    tick(2);
    g = 0;
    while (!px_valid && g < 10) begin tick(1); g++; end
    snap = {px_valid, px_row, px_col, px_rgb, px_last};
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if ({px_valid, px_row, px_col, px_rgb, px_last} !== snap) stable = 1'b0;
    end
    chk("stall_valid",  snap[18], 1);
    chk("stall_stable", stable, 1);
    ready_mode = 1;
    drain_cmp("stall");

    // three rows with the consumer stalled: the third must be dropped
    ready_mode = 0;
    fill_random(); expect_row(5'd1); send_row(5'd1, NC, 0);
    fill_random(); expect_row(5'd2); send_row(5'd2, NC, 0);
    tick(10);
    chk("ovf_before", ovf, 0);
    fill_random(); send_row(5'd3, NC, 0);
    tick(10);
    chk("ovf_set", ovf, 1);
    ready_mode = 1;
    drain_cmp("ovf");

    // reset while a row is draining
    fill_random();
    send_row(5'd20, NC, 0);
    wait_rx(30);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk("mid_rst_valid",   px_valid, 0);
    chk("mid_rst_row_err", row_err, 0);
    chk("mid_rst_ovf",     ovf, 0);
    chk("mid_rst_blanked", blanked, 1);
    rx_q.delete();
    exp_q.delete();
    model_err = 1'b0;
    tick(6);
    fill_random();
    expect_row(5'd21);
    send_row(5'd21, NC, 0);
    drain_cmp("post_rst");
    chk("post_rst_row_err", row_err, 0);

    // randomized rows with a random consumer
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      a   = 5'($urandom);
      sel = $urandom_range(0, 9);
      ns  = (sel == 0) ? NC - 1 : (sel == 1) ? NC + 1 : NC;
      nl  = (sel == 2) ? $urandom_range(1, 20) : 0;
      fill_random();
      model_row(a, ns, nl);
      send_row(a, ns, nl);
      drain_cmp("rand");
      chk("rand_row_err", row_err, model_err);
    end
    ready_mode = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Panel-side receiver for the HUB75 stream that led_driver emits. Samples sclk/latch/blank/addr/rgb in its own clock domain and reassembles each latched row into a pixel stream with a valid/ready handshake.
- Used for loopback self-test and checking on the board and in simulation: the stream is compared against painter output.
- Two ping-pong line buffers, so shifting of row N+1 overlaps draining of row N.

Parameters:
- COLS, 64, columns per row (power of 2).
- ADDR_BITS, 5, row-address width.
- SYNC_STAGES, 2, input synchroniser depth (≥2).

Ports:
- clk  in  1  sampling clock; must be ≥4× the hub_sclk toggle rate.
- resetn  in  1  synchronous, active-low reset.
- hub_sclk  in  1  shift clock.
- hub_latch  in  1  latch.
- hub_blank  in  1  output enable, active-high blank.
- hub_addr  in  ADDR_BITS  row address.
- hub_rgb0  in  3  top-half RGB.
- hub_rgb1  in  3  bottom-half RGB.
- px_valid  out  1  pixel available.
- px_ready  in  1  consumer accepts.
- px_row  out  ADDR_BITS  row address of the pixel.
- px_col  out  $clog2(COLS)  shift index; first-shifted column = 0 (matches painter x).
- px_rgb  out  6  {rgb1, rgb0}.
- px_last  out  1  high on col COLS-1.
- row_err  out  1  sticky: a committed row had ≠COLS sclk edges.
- ovf  out  1  sticky: row dropped because both banks were full.
- blanked  out  1  synchronised hub_blank.

Behaviour:
- Synchroniser:
  - All hub_* inputs pass through identical SYNC_STAGES flop chains, so they stay mutually aligned.
  - One further flop per signal gives edge detection on sclk and latch.
- Shift capture:
  - On each synced sclk rising edge, while latch is low, write {rgb1, rgb0} into the write bank at wcol, then increment wcol.
  - wcol saturates at COLS; edges beyond COLS are ignored and set an internal too_many flag.
  - sclk edges while latch is high are counted in lcnt (7 bits, saturating) and are not stored.
- Commit, evaluated on the synced latch falling edge:
  - lcnt ≠ 0: treat as a register write. Discard the row and reset wcol. See the optional feature.
  - lcnt = 0, wcol = COLS, !too_many, and a free bank exists: mark the write bank full and tag it with row = synced hub_addr sampled in that same cycle. Toggle the write bank and reset wcol.
  - lcnt = 0 and wcol ≠ COLS or too_many: drop the row, set row_err, reset wcol.
  - No free bank: drop the row, set ovf, reset wcol.
  - A bank freed by the reader in the same cycle counts as free; the commit succeeds.
  - Clear lcnt and too_many on every latch fall.
- Reader FSM:
  - R_IDLE: go to R_FETCH when the read bank is full.
  - R_FETCH: issue a buffer read at rcol. Read latency is 1 cycle. Go to R_EMIT.
  - R_EMIT: px_valid=1. Outputs stay stable until px_valid && px_ready.
    - On transfer with rcol < COLS-1: rcol+1, back to R_FETCH.
    - On transfer with rcol = COLS-1: free the bank, toggle the read bank, clear rcol, go to R_IDLE.
  - Peak throughput is 1 pixel per 2 clk. This is adequate at ≥4× oversampling.
- Reset (resetn=0 at a clk edge):
  - Outputs: px_valid=0, px_row/px_col/px_rgb=0, px_last=0, row_err=0, ovf=0, blanked=1.
  - Internal: both banks empty, wcol=rcol=lcnt=0, all synchroniser flops = 0 except blank = 1.
  - Reset mid-row or mid-drain discards everything; px_valid drops the next cycle.

Optional Feature:
- FM6126_SNOOP_EN
- Defined:
  - Adds ports reg_valid (out, 1), reg_len (out, 7) and reg_data (out, 16).
  - A 16-bit shift register collects hub_rgb0[0] on every sclk rising edge of the current row segment.
  - On a latch fall with lcnt ≠ 0: reg_data = last 16 bits shifted (MSB first), reg_len = lcnt, and reg_valid pulses for one cycle.
  - reg_* reset to 0.
- Undefined: the ports are absent and register writes are silently discarded as above.

Decomposition:
- Package hub75_pkg holds the shared constants and typedefs for driver and receiver:
  - COLS, ADDR_BITS
  - the pixel struct {row, col, rgb}
  - the FM6126 constants FM_R1=16'h7FFF and FM_R2=16'h0040
  - the reader state enum
- One sub-module, hub75_line_buf: 2×COLS×6 dual-port RAM, synchronous write, 1-cycle registered read, bank-select bit as MSB of the address.

Test Plan:
- 64 sclk pulses with rgb0=col[2:0], rgb1=~col[2:0], addr=5, then a latch pulse → 64 pixels, px_row=5, px_col 0..63 with matching rgb, px_last only on col 63.
- px_ready held low for 10 cycles mid-row → px_* stable throughout; no pixel lost or duplicated.
- Three rows committed back-to-back with px_ready=0 → rows 1 and 2 buffered, third dropped, ovf=1; releasing ready outputs rows 1 and 2 only.
- 63 sclk pulses, then latch → no pixels, row_err=1; next full row is output normally.
- FM6126 R1 sequence (64 shifts of 16'h7FFF, latch high for the last 11) → no pixels; with FM6126_SNOOP_EN: reg_valid pulse, reg_data=16'h7FFF, reg_len=11.
- resetn low for one cycle during row drain at col 30 → px_valid=0 next cycle, flags cleared, a fresh row is received correctly.
